ibex_register_file_mp: RTL and testbench
========================================

# ibex_register_file_mp

Parametrised multi-port, flop-based register file that supersedes the single-write-port latch file in the ibex core. It adds a configurable number of read and write ports and a one-cycle write staging stage with optional read bypass. It also has a hardware clear sequencer that zeroes the file on request, and keeps the optional dummy-instruction shadow r0. It sits between the ID-stage operand readers and the WB-stage writers.

## Interface
- RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4), 0 selects 32 (ADDR_WIDTH=5); NUM_WORDS = 2**ADDR_WIDTH
- DataWidth, 32, register width in bits
- NumReadPorts, 2, number of independent read ports (1..4)
- NumWritePorts, 2, number of write ports (1 or 2)
- BypassEn, 1, forward staged write data to reads
- DummyInstructions, 0, enables shadow r0 for dummy instructions
- clk_int  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low
- dummy_instr_id_i  in  1  current write/read belongs to a dummy instruction
- raddr_i  in  5*NumReadPorts  read address, port p at [5p+4:5p]
- rdata_o  out  DataWidth*NumReadPorts  read data, combinational
- waddr_i  in  5*NumWritePorts  write address per port
- wdata_i  in  DataWidth*NumWritePorts  write data per port
- we_i  in  NumWritePorts  write enable per port
- wready_o  out  1  writes accepted this cycle
- clear_req_i  in  1  request to zero all registers
- clear_busy_o  out  1  clear sequence in progress
- clear_done_o  out  1  one-cycle pulse when clear completes
- wr_collision_o  out  1  one-cycle pulse when two ports wrote the same nonzero address

## Operation
- Address bits above ADDR_WIDTH are ignored on all ports.
- Write path, stage 1:
  - When wready_o=1 and we_i[k]=1, waddr/wdata of port k are registered into staging (we_q[k], waddr_q[k], wdata_q[k]).
  - When wready_o=0, staging valid bits load 0.
- Write path, stage 2: each valid staged entry with nonzero address commits to mem on the next edge.
- Collision, both ports staged to the same nonzero address:
  - Port 0 wins; port 1 is dropped at staging.
  - wr_collision_o is registered alongside staging and is high for exactly the cycle the staged pair is present.
  - With NumWritePorts=1, wr_collision_o=0.
- Writes to address 0 never update mem[0].
- With DummyInstructions=1:
  - A staged write to address 0 that had dummy_instr_id_i=1 at acceptance commits to shadow register r0_shadow.
  - Reads of address 0 return r0_shadow while dummy_instr_id_i=1, otherwise 0.
  - With DummyInstructions=0, address 0 always reads 0.
- Read, each port independent:
  - If BypassEn=1 and a valid staged entry matches the nonzero raddr, return its wdata_q (port 0 entry has priority).
  - Otherwise return mem[raddr].
- Clear FSM, states IDLE and CLEAR:
  - wready_o = (state==IDLE) & ~clear_req_i.
  - In IDLE, clear_req_i=1 moves the FSM to CLEAR at the next edge and sets idx=1. Writes presented in that cycle are not accepted.
  - In CLEAR, each edge sets mem[idx]<=0 and idx<=idx+1. r0_shadow is cleared on the first CLEAR edge.
  - On the edge where idx==NUM_WORDS-1, the FSM returns to IDLE and clear_done_o is set for one cycle.
  - clear_req_i is ignored while in CLEAR.
  - clear_busy_o = (state==CLEAR).
- Staged writes present when CLEAR is entered still commit. They commit before the clear reaches that register, so they are overwritten.
- Reads during CLEAR return current mem contents: already-cleared entries read 0, the rest read old data.

## Timing
- Reset values:
  - All mem and r0_shadow: 0.
  - Staging valid bits: 0.
  - State: IDLE, idx=1.
  - wready_o=1, clear_busy_o=0, clear_done_o=0, wr_collision_o=0.
  - rdata_o=0.
- Write latency:
  - Write presented in cycle N is staged at the end of N and committed at the end of N+1.
  - With BypassEn=1, reads see the new value from cycle N+1.
  - With BypassEn=0, reads see the new value from cycle N+2.
- Clear duration:
  - Request sampled in cycle N; clear_busy_o is high for cycles N+1..N+NUM_WORDS-1.
  - clear_done_o pulses in cycle N+NUM_WORDS.
  - wready_o returns to 1 in cycle N+NUM_WORDS unless clear_req_i is high again.
- Read path is purely combinational: zero-cycle latency from raddr_i to rdata_o.
- Reset asserted mid-clear or mid-write immediately returns every register and output to its reset value. No partial commit survives.

## Test plan
- Write 0xDEADBEEF to x5 on port 0 in cycle 0, read x5 on port 1:
  - BypassEn=1: 0xDEADBEEF in cycle 1.
  - BypassEn=0: old value 0 in cycle 1, 0xDEADBEEF in cycle 2.
- Port 0 writes 0x11111111 and port 1 writes 0x22222222 to x7 in the same cycle:
  - wr_collision_o pulses for one cycle.
  - x7 reads 0x11111111.
  - Distinct addresses x7/x8 both commit with no collision.
- Write 0xFFFFFFFF to x0 with dummy_instr_id_i=0 -> x0 reads 0.
- DummyInstructions=1, write 0x5A5A5A5A to x0 with dummy_instr_id_i=1 -> x0 reads 0x5A5A5A5A only while dummy_instr_id_i=1.
- Fill x1..x31 with nonzero values, pulse clear_req_i, then drive we_i during busy:
  - clear_busy_o is high for 31 cycles and wready_o=0 throughout.
  - Writes during busy are dropped.
  - clear_done_o pulses once, then all registers read 0.
- RV32E=1 clear takes 15 busy cycles; raddr 0x15 aliases x5.
- Assert rst_ni low at the 10th CLEAR cycle -> all outputs 0 and state IDLE immediately; the next write after release commits normally.

Source files
------------

// File: rtl/ibex_register_file_mp.sv
// Multi-port flop-based register file with a one-cycle write staging stage,
// optional read bypass from staging, a hardware clear sequencer and an
// optional shadow r0 used by dummy instructions.
module ibex_register_file_mp #(
  parameter bit          RV32E             = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter int unsigned NumWritePorts     = 2,
  parameter bit          BypassEn          = 1'b1,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                              clk_int,
  input  logic                              rst_ni,
  input  logic                              dummy_instr_id_i,
  input  logic [5*NumReadPorts-1:0]         raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  input  logic [5*NumWritePorts-1:0]        waddr_i,
  input  logic [DataWidth*NumWritePorts-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  output logic                              wready_o,
  input  logic                              clear_req_i,
  output logic                              clear_busy_o,
  output logic                              clear_done_o,
  output logic                              wr_collision_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 2 ** AddrWidth;

  localparam logic [AddrWidth-1:0] IdxOne  = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] IdxLast = AddrWidth'(NumWords - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  clr_state_e           state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic                 clear_done_q, clear_done_d;

  // Per-port views of the write inputs, truncated to the implemented address width
  logic [AddrWidth-1:0] waddr_w [NumWritePorts];
  logic [DataWidth-1:0] wdata_w [NumWritePorts];

  // Staging stage
  logic [NumWritePorts-1:0] we_d, we_q, dummy_q;
  logic [AddrWidth-1:0]     waddr_q [NumWritePorts];
  logic [DataWidth-1:0]     wdata_q [NumWritePorts];
  logic                     collision_d, wr_collision_q;

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] r0_shadow;

  // Upper address bits are intentionally ignored when RV32E is selected
  logic unused_inputs;
  assign unused_inputs = ^{raddr_i, waddr_i, dummy_instr_id_i};

  assign wready_o       = (state_q == IDLE) & ~clear_req_i;
  assign clear_busy_o   = (state_q == CLEAR);
  assign clear_done_o   = clear_done_q;
  assign wr_collision_o = wr_collision_q;

  for (genvar k = 0; k < NumWritePorts; k++) begin : g_wport
    assign waddr_w[k] = waddr_i[5*k +: AddrWidth];
    assign wdata_w[k] = wdata_i[DataWidth*k +: DataWidth];
  end

  // Two ports targeting the same nonzero register: port 0 wins, port 1 is dropped
  if (NumWritePorts > 1) begin : g_coll
    assign collision_d = we_i[0] & we_i[1] & (waddr_w[0] == waddr_w[1]) &
                         (waddr_w[0] != '0);
  end else begin : g_no_coll
    assign collision_d = 1'b0;
  end

  // Clear sequencer: next state, index walk and completion pulse
  always_comb begin
    // NOTE: every variable is given a default first so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          idx_d   = IdxOne;
        end
      end
      CLEAR: begin
        if (idx_q == IdxLast) begin
          state_d      = IDLE;
          idx_d        = IdxOne;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IdxOne;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear sequencer state register
  always_ff @(posedge clk_int or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= IdxOne;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Which ports are accepted into staging this cycle
  always_comb begin
    we_d = '0;
    for (int k = 0; k < NumWritePorts; k++) begin
      we_d[k] = wready_o & we_i[k];
      if (k == 1 && collision_d) we_d[k] = 1'b0;
    end
  end

  // Staging registers; valid bits drop whenever writes are not accepted
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q           <= '0;
      dummy_q        <= '0;
      wr_collision_q <= 1'b0;
      for (int k = 0; k < NumWritePorts; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      we_q           <= we_d;
      wr_collision_q <= wready_o & collision_d;
      for (int k = 0; k < NumWritePorts; k++) begin
        if (we_d[k]) begin
          waddr_q[k] <= waddr_w[k];
          wdata_q[k] <= wdata_w[k];
          dummy_q[k] <= dummy_instr_id_i;
        end
      end
    end
  end

  // Register array: staged commits, then the clear sequencer overrides its target
  always_ff @(posedge clk_int or negedge rst_ni) begin
    // NOTE: the array is reset with the rest of the state so an asynchronous reset leaves every register reading zero.
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem[i] <= '0;
    end else begin
      for (int k = int'(NumWritePorts) - 1; k >= 0; k--) begin
        if (we_q[k] && waddr_q[k] != '0) mem[waddr_q[k]] <= wdata_q[k];
      end
      if (state_q == CLEAR) mem[idx_q] <= '0;
    end
  end

  if (DummyInstructions) begin : g_r0_shadow
    // Shadow r0: written only by dummy-instruction writes to x0, zeroed on the first clear step
    always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
        r0_shadow <= '0;
      end else if (state_q == CLEAR && idx_q == IdxOne) begin
        r0_shadow <= '0;
      end else begin
        for (int k = int'(NumWritePorts) - 1; k >= 0; k--) begin
          if (we_q[k] && waddr_q[k] == '0 && dummy_q[k]) r0_shadow <= wdata_q[k];
        end
      end
    end
  end else begin : g_no_r0_shadow
    logic unused_dummy_q;
    assign unused_dummy_q = ^dummy_q;
    assign r0_shadow      = '0;
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rport
    logic [AddrWidth-1:0] ra;
    logic [DataWidth-1:0] rd;
    assign ra = raddr_i[5*p +: AddrWidth];

    // Read mux: x0 / shadow r0, then staged bypass (port 0 highest), else the array
    always_comb begin
      rd = mem[ra];
      if (ra == '0) begin
        rd = (DummyInstructions && dummy_instr_id_i) ? r0_shadow : '0;
      end else if (BypassEn) begin
        for (int k = int'(NumWritePorts) - 1; k >= 0; k--) begin
          if (we_q[k] && waddr_q[k] == ra) rd = wdata_q[k];
        end
      end
    end

    assign rdata_o[DataWidth*p +: DataWidth] = rd;
  end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Self-checking bench for ibex_register_file_mp. Instance u_a: 32 registers,
// two write ports, bypass on, shadow r0 on. Instance u_b: 16 registers (RV32E),
// one write port, bypass off, no shadow r0.
module tb_ibex_register_file_mp;

  logic clk_int = 1'b0;
  logic rst_ni;
  always #5 clk_int = ~clk_int;

  // u_a stimulus / responses
  logic        a_dummy, a_wready, a_clear_req, a_busy, a_done, a_coll;
  logic [9:0]  a_raddr, a_waddr;
  logic [63:0] a_rdata, a_wdata;
  logic [1:0]  a_we;

  // u_b stimulus / responses
  logic        b_dummy, b_wready, b_clear_req, b_busy, b_done, b_coll;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [0:0]  b_we;

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .BypassEn(1'b1), .DummyInstructions(1'b1)
  ) u_a (
    .clk_int(clk_int), .rst_ni(rst_ni), .dummy_instr_id_i(a_dummy),
    .raddr_i(a_raddr), .rdata_o(a_rdata), .waddr_i(a_waddr), .wdata_i(a_wdata),
    .we_i(a_we), .wready_o(a_wready), .clear_req_i(a_clear_req),
    .clear_busy_o(a_busy), .clear_done_o(a_done), .wr_collision_o(a_coll)
  );

  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(1),
    .BypassEn(1'b0), .DummyInstructions(1'b0)
  ) u_b (
    .clk_int(clk_int), .rst_ni(rst_ni), .dummy_instr_id_i(b_dummy),
    .raddr_i(b_raddr), .rdata_o(b_rdata), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .we_i(b_we), .wready_o(b_wready), .clear_req_i(b_clear_req),
    .clear_busy_o(b_busy), .clear_done_o(b_done), .wr_collision_o(b_coll)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] a_rd(input int p);
    return a_rdata[32*p +: 32];
  endfunction

  function automatic logic [31:0] b_rd(input int p);
    return b_rdata[32*p +: 32];
  endfunction

  function automatic logic [31:0] fill_val(input int i);
    return 32'hC000_BEEF | (32'(i) << 16);
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic dummy);
    a_we    = we;
    a_waddr = {wa1, wa0};
    a_wdata = {wd1, wd0};
    a_raddr = {ra1, ra0};
    a_dummy = dummy;
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        dummy;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic dm, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.dummy = dm;
    v.ra0 = r0; v.ra1 = r1; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  // Reference model for u_a: architectural register values as seen by readers
  logic [31:0] mem_m [32];
  logic [31:0] r0_m, r0_pend;
  bit          r0_pend_v;
  bit          coll_m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [10];
    int   busy_cnt;

    // u_b vectors, one per cycle; bypass off so writes become visible two cycles later
    tbl[0] = mk(1'b1, 5'd5,    32'hDEADBEEF, 1'b0, 5'd0,    5'd5,    32'h0,        32'h0);
    tbl[1] = mk(1'b0, 5'd0,    32'h0,        1'b0, 5'd5,    5'd5,    32'h0,        32'h0);
    tbl[2] = mk(1'b0, 5'd0,    32'h0,        1'b0, 5'd5,    5'h15,   32'hDEADBEEF, 32'hDEADBEEF);
    tbl[3] = mk(1'b1, 5'd0,    32'hFFFFFFFF, 1'b1, 5'd0,    5'h10,   32'h0,        32'h0);
    tbl[4] = mk(1'b1, 5'h13,   32'h33333333, 1'b1, 5'd0,    5'd3,    32'h0,        32'h0);
    tbl[5] = mk(1'b0, 5'd0,    32'h0,        1'b1, 5'd0,    5'd3,    32'h0,        32'h0);
    tbl[6] = mk(1'b0, 5'd0,    32'h0,        1'b0, 5'h13,   5'd3,    32'h33333333, 32'h33333333);
    tbl[7] = mk(1'b1, 5'd3,    32'h44444444, 1'b0, 5'd3,    5'h15,   32'h33333333, 32'hDEADBEEF);
    tbl[8] = mk(1'b0, 5'd0,    32'h0,        1'b0, 5'd3,    5'd5,    32'h33333333, 32'hDEADBEEF);
    tbl[9] = mk(1'b0, 5'd0,    32'h0,        1'b0, 5'h13,   5'd0,    32'h44444444, 32'h0);

    // Reset
    rst_ni = 1'b0;
    a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = {5'd31, 5'd5}; a_dummy = 1'b0; a_clear_req = 1'b0;
    b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = {5'd15, 5'd5}; b_dummy = 1'b0; b_clear_req = 1'b0;
    repeat (2) @(posedge clk_int);
    @(negedge clk_int);
    rst_ni = 1'b1;
    tick();
    check("a_reset_rdata0",  a_rd(0), 32'h0);
    check("a_reset_rdata1",  a_rd(1), 32'h0);
    check("a_reset_wready",  32'(a_wready), 32'd1);
    check("a_reset_busy",    32'(a_busy), 32'd0);
    check("a_reset_done",    32'(a_done), 32'd0);
    check("a_reset_coll",    32'(a_coll), 32'd0);
    check("b_reset_rdata0",  b_rd(0), 32'h0);
    check("b_reset_wready",  32'(b_wready), 32'd1);
    check("b_reset_busy",    32'(b_busy), 32'd0);

    // Bypass: write x5 in cycle 0, visible on port 1 in cycle 1
    a_drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
    check("bypass_c0", a_rd(1), 32'h0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
    check("bypass_c1", a_rd(1), 32'hDEADBEEF);
    tick();
    check("bypass_c2", a_rd(1), 32'hDEADBEEF);

    // Same-address collision on x7: port 0 wins, one-cycle pulse
    a_drive(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, 5'd0, 1'b0);
    check("coll_before", 32'(a_coll), 32'd0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
    check("coll_pulse", 32'(a_coll), 32'd1);
    check("coll_x7_bypass", a_rd(0), 32'h11111111);
    tick();
    check("coll_drop", 32'(a_coll), 32'd0);
    check("coll_x7_mem", a_rd(1), 32'h11111111);

    // Distinct addresses x7 / x8 both commit
    a_drive(2'b11, 5'd7, 32'h00000077, 5'd8, 32'h00000088, 5'd7, 5'd8, 1'b0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0);
    check("dist_coll", 32'(a_coll), 32'd0);
    check("dist_x7", a_rd(0), 32'h00000077);
    check("dist_x8", a_rd(1), 32'h00000088);
    tick();
    check("dist_x7_mem", a_rd(0), 32'h00000077);
    check("dist_x8_mem", a_rd(1), 32'h00000088);

    // Non-dummy write to x0 is discarded
    a_drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    check("x0_nodummy_c1", a_rd(0), 32'h0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    check("x0_nodummy_shadow", a_rd(0), 32'h0);

    // Dummy write to x0 lands in the shadow, visible only while dummy is high
    a_drive(2'b01, 5'd0, 32'h5A5A5A5A, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    tick();
    check("shadow_dummy1", a_rd(0), 32'h5A5A5A5A);
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    check("shadow_dummy0", a_rd(0), 32'h0);
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    check("shadow_dummy1_again", a_rd(0), 32'h5A5A5A5A);

    // Randomized traffic against the model
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    mem_m[5] = 32'hDEADBEEF;
    mem_m[7] = 32'h00000077;
    mem_m[8] = 32'h00000088;
    r0_m = 32'h5A5A5A5A;
    r0_pend = 32'h0;
    r0_pend_v = 1'b0;
    coll_m = 1'b0;
    tick();
    for (int it = 0; it < 300; it++) begin
      logic [1:0]  we;
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [4:0]  ra [2];
      logic        dm;
      for (int k = 0; k < 2; k++) begin
        wa[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        ra[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wd[k] = $urandom;
      end
      we = 2'($urandom_range(0, 3));
      dm = 1'($urandom_range(0, 1));
      a_drive(we, wa[0], wd[0], wa[1], wd[1], ra[0], ra[1], dm);
      for (int p = 0; p < 2; p++) begin
        logic [31:0] e;
        e = (ra[p] == 5'd0) ? (dm ? r0_m : 32'h0) : mem_m[ra[p]];
        check($sformatf("rand_rd%0d_it%0d", p, it), a_rd(p), e);
      end
      check($sformatf("rand_coll_it%0d", it), 32'(a_coll), 32'(coll_m));
      // Architectural effect of this cycle's writes
      if (r0_pend_v) r0_m = r0_pend;
      r0_pend_v = 1'b0;
      coll_m = we[0] & we[1] & (wa[0] == wa[1]) & (wa[0] != 5'd0);
      for (int k = 1; k >= 0; k--) begin
        if (we[k]) begin
          if (wa[k] != 5'd0) mem_m[wa[k]] = wd[k];
          else if (dm) begin
            r0_pend = wd[k];
            r0_pend_v = 1'b1;
          end
        end
      end
      tick();
    end

    // Fill every register plus the shadow, then clear with writes attempted while busy
    a_drive(2'b01, 5'd0, 32'h5A5A5A5A, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int i = 1; i < 32; i++) begin
      a_drive(2'b01, 5'(i), fill_val(i), 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      tick();
    end
    a_clear_req = 1'b1;
    a_drive(2'b11, 5'd3, 32'h12345678, 5'd4, 32'h87654321, 5'd31, 5'd1, 1'b0);
    check("clr_req_wready", 32'(a_wready), 32'd0);
    check("clr_req_busy", 32'(a_busy), 32'd0);
    check("clr_req_x31", a_rd(0), fill_val(31));
    tick();
    a_clear_req = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      a_drive(2'b11, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'(k - 1), 5'(k), 1'b0);
      if (!a_busy) break;
      busy_cnt++;
      check($sformatf("clr_wready_k%0d", k), 32'(a_wready), 32'd0);
      check($sformatf("clr_done_k%0d", k), 32'(a_done), 32'd0);
      check($sformatf("clr_cleared_k%0d", k), a_rd(0), 32'h0);
      if (k <= 31) check($sformatf("clr_pending_k%0d", k), a_rd(1), fill_val(k));
      tick();
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_done_pulse", 32'(a_done), 32'd1);
    check("clr_wready_back", 32'(a_wready), 32'd1);
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    tick();
    check("clr_done_once", 32'(a_done), 32'd0);
    for (int r = 0; r < 32; r += 2) begin
      a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(r), 5'(r + 1), 1'b1);
      check($sformatf("clr_zero_x%0d", r), a_rd(0), 32'h0);
      check($sformatf("clr_zero_x%0d", r + 1), a_rd(1), 32'h0);
    end

    // u_b table: no bypass, address aliasing, x0 never written, single port
    for (int i = 0; i < 10; i++) begin
      b_we    = tbl[i].we;
      b_waddr = tbl[i].waddr;
      b_wdata = tbl[i].wdata;
      b_dummy = tbl[i].dummy;
      b_raddr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      check($sformatf("b_tbl%0d_rd0", i), b_rd(0), tbl[i].exp0);
      check($sformatf("b_tbl%0d_rd1", i), b_rd(1), tbl[i].exp1);
      check($sformatf("b_tbl%0d_coll", i), 32'(b_coll), 32'd0);
      tick();
    end

    // u_b clear: 15 busy cycles for 16 registers
    b_we = '0;
    b_clear_req = 1'b1;
    #1;
    check("b_clr_wready", 32'(b_wready), 32'd0);
    tick();
    b_clear_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (!b_busy) break;
      busy_cnt++;
      tick();
    end
    check("b_clr_busy_cycles", 32'(busy_cnt), 32'd15);
    check("b_clr_done", 32'(b_done), 32'd1);
    b_raddr = {5'd3, 5'd5};
    #1;
    check("b_clr_x5", b_rd(0), 32'h0);
    check("b_clr_x3", b_rd(1), 32'h0);
    tick();

    // Reset asserted during the 10th clear cycle on u_a
    a_drive(2'b01, 5'd20, 32'hA5A50020, 5'd0, 32'h0, 5'd20, 5'd0, 1'b0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 5'd0, 1'b0);
    tick();
    a_clear_req = 1'b1;
    #1;
    tick();
    a_clear_req = 1'b0;
    repeat (9) tick();
    check("rst_mid_busy", 32'(a_busy), 32'd1);
    check("rst_mid_x20_old", a_rd(0), 32'hA5A50020);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_busy_after", 32'(a_busy), 32'd0);
    check("rst_mid_wready", 32'(a_wready), 32'd1);
    check("rst_mid_done", 32'(a_done), 32'd0);
    check("rst_mid_coll", 32'(a_coll), 32'd0);
    check("rst_mid_x20", a_rd(0), 32'h0);
    @(negedge clk_int);
    rst_ni = 1'b1;
    tick();
    a_drive(2'b10, 5'd0, 32'h0, 5'd12, 32'hCAFEF00D, 5'd12, 5'd20, 1'b0);
    check("post_rst_x12_c0", a_rd(0), 32'h0);
    check("post_rst_x20", a_rd(1), 32'h0);
    tick();
    a_drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd20, 1'b0);
    check("post_rst_x12_c1", a_rd(0), 32'hCAFEF00D);
    tick();
    check("post_rst_x12_c2", a_rd(0), 32'hCAFEF00D);
    check("post_rst_busy", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
